// File: rtl/nrf_rx_controller.sv
// Receive-side sequencer for an nRF24L01: polls STATUS over SPI, reads each pending payload into
// the datapath memory, then clears RX_DR and drains the RX FIFO before going back to sleep.
module nrf_rx_controller #(
    parameter int unsigned MAX_PAYLOAD = 6,
    parameter int unsigned CSN_GAP     = 2
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_TX_Ready,
    input  logic       i_RX_DV,
    input  logic       i_Done_Sleep,
    input  logic       i_RX_DR_Set,
    input  logic       i_FIFO_Empty,
    input  logic       i_Eqz,
    input  logic [7:0] i_RX_Byte,
    output logic [7:0] o_Data_Bus,
    output logic       o_SPI_Csn,
    output logic       o_Load_TX,
    output logic       o_TX_DV,
    output logic       o_Load_RX,
    output logic       o_Load_Data_Size,
    output logic       o_Incr_Count,
    output logic       o_Load_Mem,
    output logic       o_Start_Sleep,
    output logic       o_Latch_Output,
    output logic       o_Clr_Count,
    output logic       o_Valid,
    output logic       o_Error
);

    typedef enum logic [4:0] {
        StSleepStart, StSleepWait, StCsnLow, StLoad, StSend, StTxDv, StWait, StCap, StDone,
        StEqz, StLoadMem, StIncr, StGap, StLoadSize, StLatch, StValid, StError
    } state_e;

    typedef enum logic [2:0] {
        OpPoll, OpWidth, OpPayload, OpClear, OpFifo, OpFlush, OpFlushClr
    } op_e;

    localparam int unsigned GapW = (CSN_GAP > 1) ? $clog2(CSN_GAP) : 1;

    function automatic logic [7:0] first_byte(input op_e op);
        case (op)
            OpWidth:    return 8'h60;
            OpPayload:  return 8'h61;
            OpClear:    return 8'h27;
            OpFifo:     return 8'h17;
            OpFlush:    return 8'hE2;
            OpFlushClr: return 8'h27;
            default:    return 8'hFF;
        endcase
    endfunction

    function automatic logic [7:0] second_byte(input op_e op);
        return (op == OpClear || op == OpFlushClr) ? 8'h40 : 8'hFF;
    endfunction

    function automatic logic two_byte(input op_e op);
        return op inside {OpWidth, OpClear, OpFifo, OpFlushClr};
    endfunction

    state_e          r_state, w_state_nxt;
    op_e             r_op, w_op_nxt, w_start_op;
    logic            r_idx, w_idx_nxt;
    logic            r_flag, w_flag_nxt;
    logic [GapW-1:0] r_gap, w_gap_nxt;
    logic [7:0]      r_data_bus, w_byte;
    logic            w_start, w_bad_width, w_csn_low;
    logic            r_csn, r_load_tx, r_tx_dv, r_load_rx, r_load_size, r_incr, r_load_mem;
    logic            r_start_sleep, r_latch, r_clr, r_valid, r_error;

    assign w_bad_width = (i_RX_Byte == 8'd0) || (i_RX_Byte > 8'(MAX_PAYLOAD));

    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_idx_nxt   = r_idx;
        w_flag_nxt  = r_flag;
        w_gap_nxt   = r_gap;
        w_byte      = r_data_bus;
        w_start     = 1'b0;
        w_start_op  = r_op;
        unique case (r_state)
            // Held until the registered strobe has fired once, so a pulse also follows reset.
            StSleepStart: if (r_start_sleep) w_state_nxt = StSleepWait;
            StSleepWait: begin
                if (i_Done_Sleep) begin
                    w_start    = 1'b1;
                    w_start_op = OpPoll;
                end
            end
            StCsnLow: begin
                w_state_nxt = StLoad;
                w_byte      = first_byte(r_op);
            end
            StLoad:  w_state_nxt = i_TX_Ready ? StTxDv : StSend;
            StSend:  if (i_TX_Ready) w_state_nxt = StTxDv;
            StTxDv:  w_state_nxt = StWait;
            StWait:  if (i_RX_DV) w_state_nxt = StCap;
            StCap:   w_state_nxt = StDone;
            StDone: begin
                if (r_op == OpPayload) begin
                    w_idx_nxt   = 1'b1;
                    w_state_nxt = r_idx ? StLoadMem : StEqz;
                end else if (two_byte(r_op) && !r_idx) begin
                    w_idx_nxt   = 1'b1;
                    w_state_nxt = StLoad;
                    w_byte      = second_byte(r_op);
                end else begin
                    w_state_nxt = StGap;
                    w_gap_nxt   = '0;
                    case (r_op)
                        OpPoll:  w_flag_nxt = i_RX_DR_Set;
                        OpWidth: w_flag_nxt = w_bad_width;
                        OpFifo:  w_flag_nxt = i_FIFO_Empty;
                        default: w_flag_nxt = r_flag;
                    endcase
                end
            end
            StEqz: begin
                if (i_Eqz) begin
                    w_state_nxt = StGap;
                    w_gap_nxt   = '0;
                end else begin
                    w_state_nxt = StLoad;
                    w_byte      = 8'hFF;
                end
            end
            StLoadMem: w_state_nxt = StIncr;
            StIncr:    w_state_nxt = StEqz;
            StGap: begin
                if (r_gap == GapW'(CSN_GAP - 1)) begin
                    case (r_op)
                        OpPoll:     begin w_start = r_flag;  w_start_op = OpWidth;    end
                        OpWidth:    begin w_start = r_flag;  w_start_op = OpFlush;    end
                        OpPayload:  begin w_start = 1'b1;    w_start_op = OpClear;    end
                        OpFifo:     begin w_start = !r_flag; w_start_op = OpWidth;    end
                        OpFlush:    begin w_start = 1'b1;    w_start_op = OpFlushClr; end
                        default:    w_start = 1'b0;
                    endcase
                    case (r_op)
                        OpPoll:     w_state_nxt = StSleepStart;
                        OpWidth:    w_state_nxt = StLoadSize;
                        OpClear:    w_state_nxt = StLatch;
                        OpFifo:     w_state_nxt = StSleepStart;
                        OpFlushClr: w_state_nxt = StError;
                        default:    w_state_nxt = r_state;
                    endcase
                end else begin
                    w_gap_nxt = r_gap + 1'b1;
                end
            end
            StLoadSize: begin
                w_start    = 1'b1;
                w_start_op = OpPayload;
            end
            StLatch: w_state_nxt = StValid;
            StValid: begin
                w_start    = 1'b1;
                w_start_op = OpFifo;
            end
            StError: w_state_nxt = StSleepStart;
            default: w_state_nxt = StSleepStart;
        endcase
        if (w_start) begin
            w_state_nxt = StCsnLow;
            w_op_nxt    = w_start_op;
            w_idx_nxt   = 1'b0;
        end
    end

    assign w_csn_low = w_state_nxt inside {StCsnLow, StLoad, StSend, StTxDv, StWait, StCap, StDone,
                                           StEqz, StLoadMem, StIncr};

    // Outputs are registered from the next state, so each strobe is high exactly while its state is.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_state       <= StSleepStart;
            r_op          <= OpPoll;
            r_idx         <= 1'b0;
            r_flag        <= 1'b0;
            r_gap         <= '0;
            r_data_bus    <= 8'h00;
            r_csn         <= 1'b1;
            r_load_tx     <= 1'b0;
            r_tx_dv       <= 1'b0;
            r_load_rx     <= 1'b0;
            r_load_size   <= 1'b0;
            r_clr         <= 1'b0;
            r_incr        <= 1'b0;
            r_load_mem    <= 1'b0;
            r_start_sleep <= 1'b0;
            r_latch       <= 1'b0;
            r_valid       <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_op          <= w_op_nxt;
            r_idx         <= w_idx_nxt;
            r_flag        <= w_flag_nxt;
            r_gap         <= w_gap_nxt;
            r_data_bus    <= w_byte;
            r_csn         <= !w_csn_low;
            r_load_tx     <= (w_state_nxt == StLoad);
            r_tx_dv       <= (w_state_nxt == StTxDv);
            r_load_rx     <= (w_state_nxt == StCap);
            r_load_size   <= (w_state_nxt == StLoadSize);
            r_clr         <= (w_state_nxt == StLoadSize);
            r_incr        <= (w_state_nxt == StIncr);
            r_load_mem    <= (w_state_nxt == StLoadMem);
            r_start_sleep <= (w_state_nxt == StSleepStart);
            r_latch       <= (w_state_nxt == StLatch);
            r_valid       <= (w_state_nxt == StValid);
            r_error       <= (w_state_nxt == StError);
        end
    end

    assign o_Data_Bus       = r_data_bus;
    assign o_SPI_Csn        = r_csn;
    assign o_Load_TX        = r_load_tx;
    assign o_TX_DV          = r_tx_dv;
    assign o_Load_RX        = r_load_rx;
    assign o_Load_Data_Size = r_load_size;
    assign o_Clr_Count      = r_clr;
    assign o_Incr_Count     = r_incr;
    assign o_Load_Mem       = r_load_mem;
    assign o_Start_Sleep    = r_start_sleep;
    assign o_Latch_Output   = r_latch;
    assign o_Valid          = r_valid;
    assign o_Error          = r_error;

endmodule

// File: tb/tb_nrf_rx_controller.sv
// Directed bench for nrf_rx_controller: a small datapath/radio model answers SPI bytes from a
// response queue, and every check goes through chk().
module tb_nrf_rx_controller;

    localparam int unsigned CsnGap = 2;

    logic       i_Clk = 1'b0;
    logic       i_Rst;
    logic       i_TX_Ready, i_RX_DV, i_Done_Sleep, i_RX_DR_Set, i_FIFO_Empty, i_Eqz;
    logic [7:0] i_RX_Byte;
    logic [7:0] o_Data_Bus;
    logic       o_SPI_Csn, o_Load_TX, o_TX_DV, o_Load_RX, o_Load_Data_Size, o_Incr_Count;
    logic       o_Load_Mem, o_Start_Sleep, o_Latch_Output, o_Clr_Count, o_Valid, o_Error;

    always #5 i_Clk = ~i_Clk;

    nrf_rx_controller #(.MAX_PAYLOAD(6), .CSN_GAP(CsnGap)) u_dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_TX_Ready(i_TX_Ready), .i_RX_DV(i_RX_DV),
        .i_Done_Sleep(i_Done_Sleep), .i_RX_DR_Set(i_RX_DR_Set), .i_FIFO_Empty(i_FIFO_Empty),
        .i_Eqz(i_Eqz), .i_RX_Byte(i_RX_Byte), .o_Data_Bus(o_Data_Bus), .o_SPI_Csn(o_SPI_Csn),
        .o_Load_TX(o_Load_TX), .o_TX_DV(o_TX_DV), .o_Load_RX(o_Load_RX),
        .o_Load_Data_Size(o_Load_Data_Size), .o_Incr_Count(o_Incr_Count),
        .o_Load_Mem(o_Load_Mem), .o_Start_Sleep(o_Start_Sleep),
        .o_Latch_Output(o_Latch_Output), .o_Clr_Count(o_Clr_Count), .o_Valid(o_Valid),
        .o_Error(o_Error)
    );

    // Radio + datapath model
    logic        stray_dv = 1'b0, rx_dv_m, done_sleep_m, ready_q;
    logic [7:0]  rx_reg, miso;
    logic [2:0]  cnt, size;
    logic [7:0]  mem [6];
    logic [47:0] obuf;
    int unsigned dv_cnt, sleep_cnt;
    logic [7:0]  rsp[$], sent[$], exp_q[$];
    int unsigned mem_addr[$];
    int          n_valid = 0, n_error = 0, n_sleep = 0, n_size = 0, n_mem = 0, n_rx = 0;

    assign i_RX_DV      = rx_dv_m | stray_dv;
    assign i_Done_Sleep = done_sleep_m;
    assign i_RX_DR_Set  = rx_reg[6];
    assign i_FIFO_Empty = rx_reg[0];
    assign i_Eqz        = (size == cnt);
    assign i_RX_Byte    = rx_reg;

    always @(posedge i_Clk) ready_q <= i_TX_Ready;

    always @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            rx_dv_m <= 1'b0; done_sleep_m <= 1'b0; dv_cnt <= 0; sleep_cnt <= 0;
            cnt <= 3'd0; size <= 3'd0; rx_reg <= 8'h00; miso <= 8'h00;
        end else begin
            rx_dv_m      <= 1'b0;
            done_sleep_m <= 1'b0;
            if (o_TX_DV) begin
                dv_cnt <= 3;
                if (rsp.size() > 0) miso <= rsp.pop_front();
                else                miso <= 8'h0E;
            end else if (dv_cnt != 0) begin
                dv_cnt <= dv_cnt - 1;
                if (dv_cnt == 1) rx_dv_m <= 1'b1;
            end
            if (o_Start_Sleep) begin
                sleep_cnt <= 5;
                n_sleep   <= n_sleep + 1;
            end else if (sleep_cnt != 0) begin
                sleep_cnt <= sleep_cnt - 1;
                if (sleep_cnt == 1) done_sleep_m <= 1'b1;
            end
            if (o_Load_TX) sent.push_back(o_Data_Bus);
            if (o_Load_RX) begin
                rx_reg <= miso;
                n_rx   <= n_rx + 1;
            end
            if (o_Clr_Count) cnt <= 3'd0;
            else if (o_Incr_Count) cnt <= cnt + 3'd1;
            if (o_Load_Data_Size) begin
                size   <= rx_reg[2:0];
                n_size <= n_size + 1;
            end
            if (o_Load_Mem) begin
                mem[cnt] <= rx_reg;
                mem_addr.push_back(32'(cnt));
                n_mem <= n_mem + 1;
            end
            if (o_Latch_Output) obuf <= {mem[5], mem[4], mem[3], mem[2], mem[1], mem[0]};
            if (o_Valid) n_valid <= n_valid + 1;
            if (o_Error) n_error <= n_error + 1;
        end
    end

    // Protocol monitor, sampled mid-cycle
    logic [10:0] strb;
    logic        csn_prev = 1'b1, latch_prev = 1'b0;
    int          excl_err = 0, dv_err = 0, valid_err = 0, fr_err = 0, gap_err = 0;
    int          hi_run = 100, txn_bytes = 0, last_len = 0;

    assign strb = {o_Load_TX, o_TX_DV, o_Load_RX, o_Load_Data_Size, o_Clr_Count, o_Incr_Count,
                   o_Load_Mem, o_Start_Sleep, o_Latch_Output, o_Valid, o_Error};

    always @(negedge i_Clk) begin
        if ($countones({o_Load_TX, o_TX_DV, o_Load_RX, o_Load_Data_Size, o_Incr_Count,
                        o_Load_Mem, o_Start_Sleep, o_Latch_Output}) > 1 ||
            o_Clr_Count != o_Load_Data_Size) excl_err <= excl_err + 1;
        if (o_TX_DV && !ready_q) dv_err <= dv_err + 1;
        if (o_Valid != latch_prev) valid_err <= valid_err + 1;
        latch_prev <= o_Latch_Output;
        if (o_Load_TX && (o_SPI_Csn || csn_prev)) fr_err <= fr_err + 1;
        if (o_SPI_Csn) begin
            hi_run    <= hi_run + 1;
            txn_bytes <= 0;
            if (!csn_prev) last_len <= txn_bytes;
        end else begin
            if (csn_prev && hi_run < int'(CsnGap)) gap_err <= gap_err + 1;
            hi_run    <= 0;
            txn_bytes <= txn_bytes + int'(o_Load_TX);
        end
        csn_prev <= o_SPI_Csn;
    end

    int n_vec = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_sleeps(input string tag, input int target);
        int c = 0;
        while (n_sleep < target && c < 3000) begin
            @(negedge i_Clk);
            c++;
        end
        chk({tag, "_done"}, 64'(n_sleep >= target), 64'd1);
    endtask

    task automatic check_sent(input string tag, input int base);
        chk({tag, "_nbytes"}, 64'(sent.size() - base), 64'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (base + i < sent.size()) chk({tag, "_byte"}, 64'(sent[base + i]), 64'(exp_q[i]));
            else                        chk({tag, "_byte"}, 64'h100, 64'(exp_q[i]));
        end
    endtask

    int bs, bt, bm, bv, be, bz, br;

    task automatic snap();
        bs = n_sleep; bt = sent.size(); bm = n_mem; bv = n_valid; be = n_error;
        bz = n_size; br = n_rx;
    endtask

    initial begin
        i_Rst = 1'b1; i_TX_Ready = 1'b1;
        #1;
        chk("rst_csn", 64'(o_SPI_Csn), 64'd1);
        chk("rst_bus", 64'(o_Data_Bus), 64'h00);
        chk("rst_strobes", 64'(strb), 64'h0);
        repeat (3) @(posedge i_Clk);
        @(negedge i_Clk) i_Rst = 1'b0;

        // Idle poll: STATUS=0E
        snap();
        wait_sleeps("idle", bs + 2);
        exp_q = '{8'hFF};
        check_sent("idle", bt);
        chk("idle_txn_len", 64'(last_len), 64'd1);
        chk("idle_mem", 64'(n_mem - bm), 64'd0);
        chk("idle_valid", 64'(n_valid - bv), 64'd0);

        // Three-byte payload
        snap();
        rsp = '{8'h40, 8'h0E, 8'h03, 8'h0E, 8'hAA, 8'hBB, 8'hCC, 8'h0E, 8'h0E, 8'h0E, 8'h01};
        wait_sleeps("p3", bs + 1);
        exp_q = '{8'hFF, 8'h60, 8'hFF, 8'h61, 8'hFF, 8'hFF, 8'hFF, 8'h27, 8'h40, 8'h17, 8'hFF};
        check_sent("p3", bt);
        chk("p3_mem", 64'(n_mem - bm), 64'd3);
        for (int i = 0; i < 3; i++)
            if (bm + i < mem_addr.size()) chk("p3_addr", 64'(mem_addr[bm + i]), 64'(i));
        chk("p3_valid", 64'(n_valid - bv), 64'd1);
        chk("p3_data", 64'(obuf[23:0]), 64'hCCBBAA);

        // Back-to-back payloads, no sleep in between
        snap();
        rsp = '{8'h40, 8'h0E, 8'h02, 8'h0E, 8'h11, 8'h22, 8'h0E, 8'h0E, 8'h0E, 8'h00,
                8'h0E, 8'h01, 8'h0E, 8'h33, 8'h0E, 8'h0E, 8'h0E, 8'h01};
        wait_sleeps("b2b", bs + 1);
        exp_q = '{8'hFF, 8'h60, 8'hFF, 8'h61, 8'hFF, 8'hFF, 8'h27, 8'h40, 8'h17, 8'hFF,
                  8'h60, 8'hFF, 8'h61, 8'hFF, 8'h27, 8'h40, 8'h17, 8'hFF};
        check_sent("b2b", bt);
        chk("b2b_sleeps", 64'(n_sleep - bs), 64'd1);
        chk("b2b_valid", 64'(n_valid - bv), 64'd2);
        chk("b2b_data", 64'(obuf[15:0]), 64'h2233);

        // Bad widths 7 and 0 flush the FIFO
        for (int w = 0; w < 2; w++) begin
            snap();
            rsp = '{8'h40, 8'h0E, (w == 0) ? 8'h07 : 8'h00, 8'h0E, 8'h0E, 8'h0E};
            wait_sleeps("bad", bs + 1);
            exp_q = '{8'hFF, 8'h60, 8'hFF, 8'hE2, 8'h27, 8'h40};
            check_sent("bad", bt);
            chk("bad_error", 64'(n_error - be), 64'd1);
            chk("bad_valid", 64'(n_valid - bv), 64'd0);
            chk("bad_size", 64'(n_size - bz), 64'd0);
        end

        // Width 6 is the inclusive limit
        snap();
        rsp = '{8'h40, 8'h0E, 8'h06, 8'h0E, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                8'h0E, 8'h0E, 8'h0E, 8'h01};
        wait_sleeps("w6", bs + 1);
        exp_q = '{8'hFF, 8'h60, 8'hFF, 8'h61, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                  8'h27, 8'h40, 8'h17, 8'hFF};
        check_sent("w6", bt);
        chk("w6_mem", 64'(n_mem - bm), 64'd6);
        chk("w6_valid", 64'(n_valid - bv), 64'd1);
        chk("w6_error", 64'(n_error - be), 64'd0);
        chk("w6_data", 64'(obuf), 64'h060504030201);

        // Handshake stall with a stray RX_DV during SEND
        snap();
        begin
            int c = 0;
            int dv_seen = 0;
            while (!o_Load_TX && c < 200) begin
                @(negedge i_Clk);
                c++;
            end
            chk("stall_load_seen", 64'(o_Load_TX), 64'd1);
            i_TX_Ready = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge i_Clk);
                dv_seen += int'(o_TX_DV);
                stray_dv = (k == 10);
            end
            stray_dv = 1'b0;
            chk("stall_no_dv", 64'(dv_seen), 64'd0);
            chk("stall_no_rx", 64'(n_rx - br), 64'd0);
            i_TX_Ready = 1'b1;
            @(negedge i_Clk);
            chk("stall_dv_after_ready", 64'(o_TX_DV), 64'd1);
        end
        wait_sleeps("stall", bs + 1);
        chk("stall_rx", 64'(n_rx - br), 64'd1);

        // Reset in the middle of the second payload byte
        snap();
        rsp = '{8'h40, 8'h0E, 8'h03, 8'h0E, 8'hAA, 8'hBB, 8'hCC};
        begin
            int c = 0;
            while (n_mem < bm + 1 && c < 1000) begin
                @(negedge i_Clk);
                c++;
            end
            chk("rst_mid_first_mem", 64'(n_mem - bm), 64'd1);
            c = 0;
            while (!o_Load_TX && c < 100) begin
                @(negedge i_Clk);
                c++;
            end
            chk("rst_mid_load_seen", 64'(o_Load_TX), 64'd1);
            repeat (3) @(negedge i_Clk);
            chk("rst_mid_csn_low", 64'(o_SPI_Csn), 64'd0);
            i_Rst = 1'b1;
            #1;
            chk("rst_mid_csn", 64'(o_SPI_Csn), 64'd1);
            chk("rst_mid_strobes", 64'(strb), 64'h0);
            @(negedge i_Clk);
            rsp.delete();
            @(negedge i_Clk) i_Rst = 1'b0;
            c = 0;
            while (strb == 11'h0 && c < 10) begin
                @(negedge i_Clk);
                c++;
            end
            chk("rst_mid_first_action", 64'(strb), 64'h008);
        end

        chk("mon_exclusive", 64'(excl_err), 64'd0);
        chk("mon_dv_ready", 64'(dv_err), 64'd0);
        chk("mon_valid_latch", 64'(valid_err), 64'd0);
        chk("mon_framing", 64'(fr_err), 64'd0);
        chk("mon_csn_gap", 64'(gap_err), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/nrf_rx_controller.md
# nrf_rx_controller

Sequencing FSM for the nRF24L01 receive datapath. It sits beside `datapath` and drives every one of its control inputs. It periodically polls the radio over SPI and reads each pending RX payload (1..MAX_PAYLOAD bytes) into the datapath memory. When a payload is complete it latches the 48-bit output buffer, clears RX_DR, and repeats until the RX FIFO is empty.

## Interface
- MAX_PAYLOAD, 6: largest accepted payload width in bytes; must be ≤ 6 (48-bit output, 3-bit address).
- CSN_GAP, 2: minimum clock cycles CSN is held high between SPI transactions.
- i_Clk  in  1  system clock; the only clock.
- i_Rst  in  1  asynchronous, active-high reset.
- i_TX_Ready  in  1  SPI transceiver is ready for a byte.
- i_RX_DV  in  1  one-cycle pulse; received SPI byte is valid.
- i_Done_Sleep  in  1  sleep timer has expired.
- i_RX_DR_Set  in  1  captured STATUS has bit 6 (RX_DR) set.
- i_FIFO_Empty  in  1  captured FIFO_STATUS has bit 0 (RX_EMPTY) set.
- i_Eqz  in  1  data-size register equals the memory address counter.
- i_RX_Byte  in  8  RX register output, used for the width check.
- o_Data_Bus  out  8  command or data byte presented to the TX register.
- o_SPI_Csn  out  1  SPI chip select, active low.
- o_Load_TX, o_TX_DV, o_Load_RX, o_Load_Data_Size, o_Incr_Count, o_Load_Mem, o_Start_Sleep, o_Latch_Output  out  1 each  one-cycle datapath strobes.
- o_Clr_Count  out  1  one-cycle clear of the address counter.
- o_Valid  out  1  one-cycle pulse; the output buffer holds a new payload.
- o_Error  out  1  one-cycle pulse; a bad width was detected and the FIFO was flushed.

## Operation
- All outputs are registered.
- Reset values:
  - o_SPI_Csn=1.
  - All strobes, o_Valid and o_Error are 0.
  - o_Data_Bus=8'h00.
  - State is SLEEP_START.
- Byte-transfer subsequence XFER(b):
  - LOAD: o_Data_Bus=b and o_Load_TX=1.
  - SEND: wait for i_TX_Ready, then assert o_TX_DV for exactly 1 cycle.
  - WAIT: wait for i_RX_DV.
  - CAP: assert o_Load_RX for 1 cycle.
  - DONE: 1 cycle, so i_RX_Byte and the flags are valid.
- Transaction framing:
  - o_SPI_Csn goes low 1 cycle before the first LOAD.
  - It goes high 1 cycle after the last DONE.
  - It then stays high for ≥ CSN_GAP cycles before the next transaction.
- Top-level states, in order:
  - SLEEP_START: assert o_Start_Sleep for 1 cycle, then go to SLEEP_WAIT.
  - SLEEP_WAIT: wait for i_Done_Sleep, then go to POLL.
  - POLL: one transaction XFER(8'hFF), NOP. The captured byte is STATUS. If i_RX_DR_Set=0, go to SLEEP_START; otherwise go to WIDTH.
  - WIDTH: one transaction XFER(8'h60), R_RX_PL_WID, then XFER(8'hFF).
    - If i_RX_Byte is 0 or greater than MAX_PAYLOAD, go to FLUSH.
    - Otherwise assert o_Load_Data_Size and o_Clr_Count together for 1 cycle, then go to PAYLOAD.
  - PAYLOAD: one transaction starting with XFER(8'h61), R_RX_PAYLOAD. Then loop:
    - If i_Eqz=1, end the transaction and go to CLEAR.
    - Otherwise run XFER(8'hFF), then assert o_Load_Mem for 1 cycle, then o_Incr_Count for 1 cycle on the following cycle.
    - i_Eqz is evaluated only ≥ 1 cycle after o_Incr_Count.
  - CLEAR: one transaction XFER(8'h27), W_REGISTER STATUS, then XFER(8'h40). Then assert o_Latch_Output for 1 cycle, then o_Valid for 1 cycle on the next cycle.
  - FIFO: one transaction XFER(8'h17), R_REGISTER FIFO_STATUS, then XFER(8'hFF). If i_FIFO_Empty=1, go to SLEEP_START; otherwise go to WIDTH (no sleep).
  - FLUSH: one transaction XFER(8'hE2), FLUSH_RX. Then one transaction XFER(8'h27), XFER(8'h40). Pulse o_Error for 1 cycle, then go to SLEEP_START. o_Valid is not pulsed.
- Strobe exclusivity: the strobes are mutually exclusive except for the o_Load_Data_Size + o_Clr_Count pair.
- Reset mid-operation:
  - The FSM returns to SLEEP_START immediately (asynchronously).
  - o_SPI_Csn goes to 1 immediately, with no waiting for the SPI byte.
  - The datapath reset clears the counter and the transceiver.

## Timing
- SEND:
  - If i_TX_Ready is already 1 in the cycle after LOAD, o_TX_DV follows LOAD by exactly 1 cycle.
  - Otherwise o_TX_DV is asserted in the cycle after i_TX_Ready is sampled high.
  - o_TX_DV is never asserted while i_TX_Ready=0.
- CAP: o_Load_RX is asserted the cycle after i_RX_DV is sampled high. An i_RX_DV pulse outside WAIT is ignored.
- i_Done_Sleep arriving in the same cycle as o_Start_Sleep is ignored; only SLEEP_WAIT samples it.
- The width boundary is inclusive: i_RX_Byte=MAX_PAYLOAD is accepted, MAX_PAYLOAD+1 is rejected.
- o_Valid follows o_Latch_Output by exactly 1 cycle.
- Minimum CSN-high gap:
  - CSN_GAP cycles between any two transactions.
  - Also CSN_GAP cycles between the PAYLOAD transaction and the CLEAR transaction.

## Test plan
- Idle poll: STATUS=8'h0E → exactly one NOP transaction (o_Data_Bus=8'hFF, CSN low for 1 byte), then o_Start_Sleep again. No o_Load_Mem, no o_Valid.
- 3-byte payload: STATUS=8'h40, width=3, bytes AA BB CC, FIFO_STATUS=8'h01 → SPI byte sequence 60 FF / 61 FF FF FF / 27 40 / 17 FF. Exactly three o_Load_Mem at addresses 0, 1, 2. One o_Valid, with o_Data[23:0]=CCBBAA.
- Back-to-back payloads: FIFO_STATUS=8'h00 after the first payload → WIDTH restarts with no o_Start_Sleep. Two o_Valid pulses total.
- Bad width: width=7 (and separately width=0) → SPI bytes E2, then 27 40. One o_Error, no o_Valid, no o_Load_Data_Size. Width=6 is accepted with 6 loads.
- Handshake stall: hold i_TX_Ready=0 for 20 cycles after LOAD → o_TX_DV stays 0, then asserts the cycle after i_TX_Ready=1. A stray i_RX_DV during SEND is ignored.
- Reset mid-payload: assert i_Rst during the second payload byte → o_SPI_Csn=1 and all strobes 0 within the same cycle. After release, the first action is o_Start_Sleep.
